// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet constants and helpers for the 128-bit receive datapath.
//   ETH_FCS_LEN    : number of FCS bytes trailing every frame
//   ETH_MIN_FRAME  : smallest legal frame, FCS included
//   ETH_MAX_FRAME  : largest legal frame, FCS included
//   outAction_t    : what the FCS stripper does with its hold register
//   keepFromCount  : turns a byte count (0..16) into a contiguous tkeep
// ---------------------------------------------------------------------------
package eth_pkg;

   localparam int ETH_FCS_LEN   = 4;
   localparam int ETH_MIN_FRAME = 64;
   localparam int ETH_MAX_FRAME = 1518;

   // Decision taken each cycle for the beat sitting in the hold register
   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_FULL,
      ACT_MERGE_LAST,
      ACT_TRIM_LAST,
      ACT_RUNT_LAST
   } outAction_t;

   // A count of 0 yields an all-zero mask, 16 yields all ones
   function automatic logic [15:0] keepFromCount(input logic [4:0] count);
      keepFromCount = 16'hFFFF >> (5'd16 - count);
   endfunction

endpackage

// File: rtl/axis_keep_count.sv
// ---------------------------------------------------------------------------
// axis_keep_count
// Combinational byte counter for one 128-bit beat.
//   keep_i  : contiguous byte enables, bit 0 first
//   count_o : index of the highest set bit plus one; an all-zero keep is
//             treated as a full 16-byte beat
// ---------------------------------------------------------------------------
module axis_keep_count (
   input  logic [15:0] keep_i,
   output logic [4:0]  count_o
);

   // Walk upwards so the highest enabled lane wins
   always_comb begin
      count_o = 5'd16;
      for (int i = 0; i < 16; i++) begin
         if (keep_i[i]) begin
            count_o = 5'(i + 1);
         end
      end
   end

endmodule

// File: rtl/axis_eth_fcs_strip_128.sv
// ---------------------------------------------------------------------------
// axis_eth_fcs_strip_128
// Removes the 4-byte FCS from a 128-bit AXI stream, measures each frame and
// flags runt/oversize frames. Fixed 2-cycle latency, no backpressure.
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : incoming frame beats, FCS included
//   m_axis_*          : outgoing frame beats, FCS removed; tuser[0] flags
//                       upstream error, runt or oversize on the last beat
//   frame_len         : stripped frame length, qualified by frame_len_valid
//   frame_len_valid   : pulses with the outgoing tlast beat
//   error_runt        : pulses with tlast when the frame is below MIN_LEN
//   error_oversize    : pulses with tlast when the frame is above MAX_LEN
// ---------------------------------------------------------------------------
module axis_eth_fcs_strip_128
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1,
   parameter int MIN_LEN    = ETH_MIN_FRAME,
   parameter int MAX_LEN    = ETH_MAX_FRAME
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic [15:0]           frame_len,
   output logic                  frame_len_valid,
   output logic                  error_runt,
   output logic                  error_oversize
);

   generate
      if (DATA_WIDTH != 128) begin : gBadWidth
         $error("axis_eth_fcs_strip_128 only supports DATA_WIDTH = 128");
      end
   endgenerate

   localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
   localparam logic [15:0] FCS_LEN_W = 16'(ETH_FCS_LEN);
   localparam logic [4:0]  FCS_CNT   = 5'(ETH_FCS_LEN);

   logic                  hValid_q, hValid_d;
   logic                  hLast_q, hLast_d;
   logic [DATA_WIDTH-1:0] hData_q, hData_d;
   logic [KEEP_WIDTH-1:0] hKeep_q, hKeep_d;
   logic [USER_WIDTH-1:0] hUser_q, hUser_d;
   logic [15:0]           hTotal_q, hTotal_d;
   logic [15:0]           lenCount_q, lenCount_d;

   logic [DATA_WIDTH-1:0] mData_q, mData_d;
   logic [KEEP_WIDTH-1:0] mKeep_q, mKeep_d;
   logic                  mValid_q, mValid_d;
   logic                  mLast_q, mLast_d;
   logic [USER_WIDTH-1:0] mUser_q, mUser_d;
   logic [15:0]           frameLen_q, frameLen_d;
   logic                  frameLenValid_q, frameLenValid_d;
   logic                  runt_q, runt_d;
   logic                  over_q, over_d;

   logic [4:0]  hCount;
   logic [4:0]  iCount;
   logic [16:0] lenSum;
   logic [15:0] iTotal;
   logic [15:0] frameTotal;
   logic        isLast;
   logic        runtHit;
   logic        overHit;
   logic [4:0]  outCount;
   outAction_t  action;

   axis_keep_count uHoldCount (
      .keep_i  (hKeep_q),
      .count_o (hCount)
   );

   axis_keep_count uInCount (
      .keep_i  (s_axis_tkeep),
      .count_o (iCount)
   );

   // Decide what to emit for the held beat. A last beat of 4 bytes or fewer
   // carries only FCS, so the held beat becomes the frame's last beat and
   // the incoming beat is swallowed. The running total is saturating and
   // the total snapshot travels with the held beat so a trimmed last beat
   // still knows its frame length after the counter has cleared.
   always_comb begin
      lenSum = {1'b0, lenCount_q} + {12'd0, iCount};
      iTotal = lenSum[16] ? 16'hFFFF : lenSum[15:0];

      action = ACT_FULL;
      if (!hValid_q) begin
         action = ACT_IDLE;
      end else if (!hLast_q && s_axis_tvalid && s_axis_tlast && (iCount <= FCS_CNT)) begin
         action = ACT_MERGE_LAST;
      end else if (hLast_q && (hCount > FCS_CNT)) begin
         action = ACT_TRIM_LAST;
      end else if (hLast_q) begin
         action = ACT_RUNT_LAST;
      end

      frameTotal = (action == ACT_MERGE_LAST) ? iTotal : hTotal_q;
      isLast     = (action == ACT_MERGE_LAST) || (action == ACT_TRIM_LAST) ||
                   (action == ACT_RUNT_LAST);
      runtHit    = isLast && ((action == ACT_RUNT_LAST) || (frameTotal < MIN_LEN_W));
      overHit    = isLast && (frameTotal > MAX_LEN_W);

      case (action)
         ACT_FULL:       outCount = 5'd16;
         ACT_MERGE_LAST: outCount = 5'd16 - FCS_CNT + iCount;
         ACT_TRIM_LAST:  outCount = hCount - FCS_CNT;
         ACT_RUNT_LAST:  outCount = 5'd1;
         default:        outCount = 5'd0;
      endcase

      hValid_d = s_axis_tvalid && (action != ACT_MERGE_LAST);
      hLast_d  = s_axis_tlast;
      hData_d  = s_axis_tdata;
      hKeep_d  = s_axis_tkeep;
      hUser_d  = s_axis_tuser;
      hTotal_d = iTotal;

      lenCount_d = lenCount_q;
      if (s_axis_tvalid) begin
         lenCount_d = s_axis_tlast ? 16'd0 : iTotal;
      end

      mData_d  = '0;
      mKeep_d  = '0;
      mValid_d = 1'b0;
      mLast_d  = 1'b0;
      mUser_d  = '0;
      if (action != ACT_IDLE) begin
         mData_d    = hData_q;
         mKeep_d    = keepFromCount(outCount);
         mValid_d   = 1'b1;
         mLast_d    = isLast;
         mUser_d    = hUser_q;
         mUser_d[0] = hUser_q[0] | ((action == ACT_MERGE_LAST) & s_axis_tuser[0]) |
                      runtHit | overHit;
      end

      frameLen_d = frameLen_q;
      if (isLast) begin
         frameLen_d = (frameTotal > FCS_LEN_W) ? (frameTotal - FCS_LEN_W) : 16'd1;
      end
      frameLenValid_d = isLast;
      runt_d          = runtHit;
      over_d          = overHit;
   end

   // All state, hold register and output registers share one synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         hValid_q        <= 1'b0;
         hLast_q         <= 1'b0;
         hData_q         <= '0;
         hKeep_q         <= '0;
         hUser_q         <= '0;
         hTotal_q        <= '0;
         lenCount_q      <= '0;
         mData_q         <= '0;
         mKeep_q         <= '0;
         mValid_q        <= 1'b0;
         mLast_q         <= 1'b0;
         mUser_q         <= '0;
         frameLen_q      <= '0;
         frameLenValid_q <= 1'b0;
         runt_q          <= 1'b0;
         over_q          <= 1'b0;
      end else begin
         hValid_q        <= hValid_d;
         hLast_q         <= hLast_d;
         hData_q         <= hData_d;
         hKeep_q         <= hKeep_d;
         hUser_q         <= hUser_d;
         hTotal_q        <= hTotal_d;
         lenCount_q      <= lenCount_d;
         mData_q         <= mData_d;
         mKeep_q         <= mKeep_d;
         mValid_q        <= mValid_d;
         mLast_q         <= mLast_d;
         mUser_q         <= mUser_d;
         frameLen_q      <= frameLen_d;
         frameLenValid_q <= frameLenValid_d;
         runt_q          <= runt_d;
         over_q          <= over_d;
      end
   end

   assign m_axis_tdata    = mData_q;
   assign m_axis_tkeep    = mKeep_q;
   assign m_axis_tvalid   = mValid_q;
   assign m_axis_tlast    = mLast_q;
   assign m_axis_tuser    = mUser_q;
   assign frame_len       = frameLen_q;
   assign frame_len_valid = frameLenValid_q;
   assign error_runt      = runt_q;
   assign error_oversize  = over_q;

endmodule

// File: tb/tb_axis_eth_fcs_strip_128.sv
// ---------------------------------------------------------------------------
// tb_axis_eth_fcs_strip_128
// Drives whole frames into the FCS stripper and compares every output beat
// against expectations derived from the frame length alone.
// ---------------------------------------------------------------------------
module tb_axis_eth_fcs_strip_128;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] s_axis_tdata;
   logic [15:0]  s_axis_tkeep;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic [0:0]   s_axis_tuser;
   logic [127:0] m_axis_tdata;
   logic [15:0]  m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic [0:0]   m_axis_tuser;
   logic [15:0]  frame_len;
   logic         frame_len_valid;
   logic         error_runt;
   logic         error_oversize;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
      logic         user0;
      int           cycle;
      logic [15:0]  flen;
      logic         runt;
      logic         over;
   } expBeat_t;

   expBeat_t expQ[$];
   int       testsRun    = 0;
   int       testsFailed = 0;
   int       cycleCount  = 0;
   logic     monitorOn   = 1'b0;

   axis_eth_fcs_strip_128 dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tuser    (s_axis_tuser),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tuser    (m_axis_tuser),
      .frame_len       (frame_len),
      .frame_len_valid (frame_len_valid),
      .error_runt      (error_runt),
      .error_oversize  (error_oversize)
   );

   // Free-running clock and cycle counter used to check the fixed latency
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] byteMask(input int n);
      logic [31:0] ones;
      ones = (32'd1 << n) - 32'd1;
      byteMask = (n >= 16) ? 16'hFFFF : ones[15:0];
   endfunction

   // Sends one frame of len bytes without gaps, then gapAfter idle cycles.
   // Expected output beats follow from the stripped length only: output beat
   // k is input beat k, two cycles later.
   task automatic applyStimulus(input int len, input logic lastErr, input int gapAfter);
      int       nBeats;
      int       outLen;
      int       outBeats;
      int       bytes;
      logic     runt;
      logic     over;
      expBeat_t e;
      nBeats   = (len + 15) / 16;
      outLen   = (len >= 5) ? len - 4 : 1;
      outBeats = (outLen + 15) / 16;
      runt     = (len < 64);
      over     = (len > 1518);
      for (int b = 0; b < nBeats; b++) begin
         @(posedge clk);
         #1;
         bytes         = (b == nBeats - 1) ? len - 16 * b : 16;
         s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
         s_axis_tkeep  = byteMask(bytes);
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (b == nBeats - 1);
         s_axis_tuser  = (b == nBeats - 1) ? lastErr : 1'b0;
         if (b < outBeats) begin
            e.data  = s_axis_tdata;
            e.last  = (b == outBeats - 1);
            e.keep  = e.last ? byteMask(outLen - 16 * b) : 16'hFFFF;
            e.user0 = e.last ? (lastErr | runt | over) : 1'b0;
            e.cycle = cycleCount + 2;
            e.flen  = 16'(outLen);
            e.runt  = runt;
            e.over  = over;
            expQ.push_back(e);
         end
      end
      for (int g = 0; g < gapAfter; g++) begin
         @(posedge clk);
         #1;
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
      end
   endtask

   task automatic waitDrain();
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      for (int i = 0; i < 50 && expQ.size() != 0; i++) begin
         @(posedge clk);
      end
      checkOutput("drain pending beats", 128'(expQ.size()), 128'(0));
   endtask

   // Scoreboard: every valid output beat is matched against the oldest
   // expected beat; idle cycles must not carry any pulse
   always @(negedge clk) begin : monitorProc
      expBeat_t e;
      if (monitorOn && !rst) begin
         if (m_axis_tvalid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected tvalid", 128'(1), 128'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("tdata", m_axis_tdata, e.data);
               checkOutput("tkeep", 128'(m_axis_tkeep), 128'(e.keep));
               checkOutput("tlast", 128'(m_axis_tlast), 128'(e.last));
               checkOutput("tuser0", 128'(m_axis_tuser[0]), 128'(e.user0));
               checkOutput("latency cycle", 128'(cycleCount), 128'(e.cycle));
               checkOutput("frame_len_valid", 128'(frame_len_valid), 128'(e.last));
               if (e.last) begin
                  checkOutput("frame_len", 128'(frame_len), 128'(e.flen));
                  checkOutput("error_runt", 128'(error_runt), 128'(e.runt));
                  checkOutput("error_oversize", 128'(error_oversize), 128'(e.over));
               end else begin
                  checkOutput("pulses mid-frame", 128'({error_runt, error_oversize}), 128'(0));
               end
            end
         end else begin
            checkOutput("pulses while idle",
                        128'({frame_len_valid, error_runt, error_oversize}), 128'(0));
         end
      end
   end

   // Main sequence: reset values, test-plan frames, length boundaries,
   // reset in the middle of a frame, then recovery
   initial begin
      int boundaryLens[11] = '{4, 5, 17, 19, 21, 31, 32, 33, 63, 1518, 1519};
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset tvalid", 128'(m_axis_tvalid), 128'(0));
      checkOutput("reset tlast", 128'(m_axis_tlast), 128'(0));
      checkOutput("reset tkeep", 128'(m_axis_tkeep), 128'(0));
      checkOutput("reset tdata", m_axis_tdata, 128'(0));
      checkOutput("reset frame_len", 128'(frame_len), 128'(0));
      checkOutput("reset pulses", 128'({frame_len_valid, error_runt, error_oversize}), 128'(0));
      rst       = 1'b0;
      monitorOn = 1'b1;

      applyStimulus(64, 1'b0, 1);
      applyStimulus(66, 1'b0, 1);
      applyStimulus(20, 1'b0, 1);
      applyStimulus(3, 1'b0, 1);
      applyStimulus(100, 1'b0, 0);
      applyStimulus(100, 1'b1, 2);
      applyStimulus(1522, 1'b0, 1);
      foreach (boundaryLens[i]) begin
         applyStimulus(boundaryLens[i], 1'b0, int'($urandom_range(0, 1)));
      end
      waitDrain();

      monitorOn = 1'b0;
      for (int b = 0; b < 3; b++) begin
         @(posedge clk);
         #1;
         s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
         s_axis_tkeep  = 16'hFFFF;
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = 1'b0;
      end
      @(posedge clk);
      #1;
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid-frame reset tvalid", 128'(m_axis_tvalid), 128'(0));
      checkOutput("mid-frame reset tkeep", 128'(m_axis_tkeep), 128'(0));
      rst = 1'b0;
      expQ.delete();
      monitorOn = 1'b1;

      applyStimulus(40, 1'b0, 0);
      applyStimulus(64, 1'b1, 0);
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/axis_eth_fcs_strip_128.md
# axis_eth_fcs_strip_128

Strips the 4-byte Ethernet FCS from the 128-bit AXI stream produced by the 128-bit XGMII receiver and tags length errors. It sits directly downstream of the receiver and upstream of the MAC RX FIFO. No backpressure is used on either side. It has a fixed latency of 2 cycles and supports back-to-back frames.

## Interface
- DATA_WIDTH, 128, stream width; only 128 is supported, any other value is an elaboration error.
- KEEP_WIDTH, DATA_WIDTH/8, byte enables.
- USER_WIDTH, 1, tuser width; bit 0 is the bad-frame flag, the upper bits are passed through unchanged (PTP timestamp).
- MIN_LEN, 64, minimum frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum frame length in bytes, FCS included.
- Ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
  - s_axis_tdata  in  128  frame data including FCS.
  - s_axis_tkeep  in  16  byte enables, contiguous from bit 0.
  - s_axis_tvalid  in  1  beat valid.
  - s_axis_tlast  in  1  last beat of frame.
  - s_axis_tuser  in  USER_WIDTH  bit 0 is the upstream error.
  - m_axis_tdata  out  128  frame data without FCS.
  - m_axis_tkeep  out  16  byte enables.
  - m_axis_tvalid  out  1  beat valid.
  - m_axis_tlast  out  1  last beat.
  - m_axis_tuser  out  USER_WIDTH  bit 0 is the OR of the upstream error, runt and oversize.
  - frame_len  out  16  frame length with FCS removed, valid with frame_len_valid.
  - frame_len_valid  out  1  one-cycle pulse with the output tlast beat.
  - error_runt  out  1  one-cycle pulse, frame shorter than MIN_LEN.
  - error_oversize  out  1  one-cycle pulse, frame longer than MAX_LEN.

## Operation
- Byte count of a beat: n = (index of the highest set tkeep bit) + 1. A beat with tkeep == 0 counts as n = 16.
- Hold register H stores the previous input beat (data, n, last, user, valid).
- Each cycle the output registers are computed from H and the current input beat I:
  - H valid, H not last, I valid, I last, I.n ≤ 4: emit H as the last beat with count 12 + I.n. I is absorbed (FCS only) and H is invalid next cycle. user[0] = H.user[0] | I.user[0].
  - H valid, H last, H.n ≥ 5: emit H with count H.n − 4, tlast = 1.
  - H valid, H last, H.n ≤ 4 (single-beat frame of 4 bytes or fewer): emit 1 byte, tkeep = 16'h0001, tlast = 1, user[0] = 1, error_runt pulses.
  - H valid, H not last, any other I: emit H full (tkeep = 16'hFFFF), not last.
  - H invalid: m_axis_tvalid = 0.
- I is loaded into H unless it was absorbed.
- Output tkeep for a count c is {16{1'b1}} >> (16 − c).
- Length counter, 16 bits:
  - Sums the input n of each beat, including FCS bytes.
  - Saturates at 16'hFFFF.
  - Clears after each input tlast beat.
  - The first beat after reset or after a tlast starts a new frame.
- At the output tlast:
  - frame_len = total − 4, with a floor of 1.
  - error_runt pulses if total < MIN_LEN.
  - error_oversize pulses if total > MAX_LEN.
  - m_axis_tuser[0] is set if either of these fires.
- tuser[USER_WIDTH−1:1] is taken from the beat that supplies the output data.

## Timing
- Latency: the input beat at cycle t appears at the output at cycle t+2. This holds for every beat, including trimmed last beats.
- Back-to-back frames, where I is the first beat of frame B while H holds frame A's last beat, are emitted without a gap.
- An absorbed FCS-only beat creates a 1-cycle gap in m_axis_tvalid.
- Reset clears H, the counter, all m_axis outputs (tvalid, tlast and tkeep = 0, data = 0), frame_len and all pulses.
- After a reset in the middle of a frame, the remaining upstream beats form a new truncated frame with a normal FCS strip. This is accepted behaviour.
- All outputs are registered.

## Structure
- Shared package eth_pkg:
  - ETH_FCS_LEN = 4.
  - ETH_MIN_FRAME = 64.
  - ETH_MAX_FRAME = 1518.
- Sub-module axis_keep_count: combinational, tkeep[15:0] in, 5-bit count out. Two instances are used, one for the H path and one for the I path.

## Test plan
- 64-byte frame (4 beats, last tkeep 16'hFFFF) → 4 output beats, the last with tkeep 16'h0FFF; frame_len = 60; no errors.
- 66-byte frame (last beat n = 2) → 4 output beats: beats 0–2 unchanged, the 4th (the original beat 3) with tkeep 16'h3FFF and tlast; the input beat 4 is absorbed; frame_len = 62.
- 20-byte frame (2 beats, n = 4 on the last) → 1 output beat, tkeep 16'hFFFF, tlast, tuser[0] = 1, error_runt pulse.
- 3-byte single beat → 1 output beat, tkeep 16'h0001, tuser[0] = 1, error_runt pulse.
- Two back-to-back 100-byte frames with upstream tuser[0] = 1 on the second frame's last beat → outputs contiguous; only the second frame's tlast beat carries tuser[0] = 1.
- 1522-byte frame → error_oversize pulse and tuser[0] = 1. Reset asserted mid-frame → m_axis_tvalid = 0 in the next cycle.
